// File: rtl/seven_segment_pkg.sv
// Shared types, font table and polarity helper for the seven-segment decoder.
// Patterns are kept active-high {dp,g,f,e,d,c,b,a} until the output register.
package seven_segment_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_OFF = 8'h00;
  localparam seg_t SEG_ALL = 8'hFF;

  // Lowercase b and d keep them distinct from 8 and 0.
  localparam seg_t FONT [0:15] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  function automatic seg_t apply_polarity(seg_t s, bit active_low);
    return active_low ? ~s : s;
  endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// Hex nibble to registered seven-segment pattern with lamp-test/blank overrides.
// One cycle latency, no flow control; async reset forces all segments off.
module seven_segment_decoder
  import seven_segment_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] DIGIT,
  input  logic       DP,
  input  logic       BLANK,
  input  logic       LAMP_TEST,
  output logic [7:0] SEGMENT
);

  localparam seg_t L_OFF_PINS = apply_polarity(SEG_OFF, ACTIVE_LOW);

  seg_t w_font;
  seg_t w_pattern;
  seg_t r_segment;

  always_comb begin
    w_font    = FONT[DIGIT];
    w_pattern = {DP, w_font[6:0]};
    // Lamp test outranks blanking so a blanked display can still be tested.
    if (LAMP_TEST) begin
      w_pattern = SEG_ALL;
    end else if (BLANK) begin
      w_pattern = SEG_OFF;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_segment <= L_OFF_PINS;
    end else begin
      r_segment <= apply_polarity(w_pattern, ACTIVE_LOW);
    end
  end

  assign SEGMENT = r_segment;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Bench for seven_segment_decoder: both polarities side by side, directed and random checks.
module tb_seven_segment_decoder;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DIGIT;
  logic       DP;
  logic       BLANK;
  logic       LAMP_TEST;
  logic [7:0] seg_hi;
  logic [7:0] seg_lo;

  int n_cmp = 0;
  int n_err = 0;

  // Lit segments of each glyph, by letter name.
  string GLYPH [16] = '{
    "abcdef", "bc",     "abdeg",  "abcdg",
    "bcfg",   "acdfg",  "acdefg", "abc",
    "abcdefg","abcdfg", "abcefg", "cdefg",
    "adef",   "bcdeg",  "adefg",  "aefg"
  };

  always #5 CLK = ~CLK;

  seven_segment_decoder #(.ACTIVE_LOW(1'b1)) u_dut_hi (
    .CLK(CLK), .RESET(RESET), .DIGIT(DIGIT), .DP(DP),
    .BLANK(BLANK), .LAMP_TEST(LAMP_TEST), .SEGMENT(seg_hi)
  );

  seven_segment_decoder #(.ACTIVE_LOW(1'b0)) u_dut_lo (
    .CLK(CLK), .RESET(RESET), .DIGIT(DIGIT), .DP(DP),
    .BLANK(BLANK), .LAMP_TEST(LAMP_TEST), .SEGMENT(seg_lo)
  );

  function automatic logic [7:0] model(input logic [3:0] d, input logic dp,
                                       input logic blank, input logic lt, input bit al);
    logic [7:0] lit;
    string g;
    lit = 8'h00;
    if (lt) begin
      lit = 8'hFF;
    end else if (!blank) begin
      g = GLYPH[d];
      for (int i = 0; i < g.len(); i++) lit[int'(g[i]) - 97] = 1'b1;
      lit[7] = dp;
    end
    return al ? ~lit : lit;
  endfunction

  task automatic drive(input logic [3:0] d, input logic dp, input logic bl, input logic lt);
    DIGIT = d; DP = dp; BLANK = bl; LAMP_TEST = lt;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    drive(4'h8, 1'b1, 1'b0, 1'b0);
    tick();
    #2;
    RESET = 1'b1;
    #1;
    n_cmp++;
    if (seg_hi !== 8'hFF) begin
      $display("FAIL reset_async_hi: got %02h want FF", seg_hi); n_err++;
    end
    n_cmp++;
    if (seg_lo !== 8'h00) begin
      $display("FAIL reset_async_lo: got %02h want 00", seg_lo); n_err++;
    end
    tick();
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    RESET = 1'b0;
    #1;
    n_cmp++;
    if (seg_hi !== 8'hFF) begin
      $display("FAIL reset_hold: got %02h want FF", seg_hi); n_err++;
    end
    tick();
    n_cmp++;
    if (seg_hi !== 8'hC0) begin
      $display("FAIL reset_release: got %02h want C0", seg_hi); n_err++;
    end
  endtask

  task automatic test_font_sweep();
    logic [7:0] exp_tab [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };
    for (int i = 0; i < 16; i++) begin
      drive(4'(i), 1'b0, 1'b0, 1'b0);
      tick();
      n_cmp++;
      if (seg_hi !== exp_tab[i]) begin
        $display("FAIL font_%0h: got %02h want %02h", i, seg_hi, exp_tab[i]); n_err++;
      end
    end
  endtask

  task automatic test_dp();
    drive(4'h8, 1'b1, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (seg_hi !== 8'h00) begin
      $display("FAIL dp_8: got %02h want 00", seg_hi); n_err++;
    end
    drive(4'h1, 1'b1, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (seg_hi !== 8'h79) begin
      $display("FAIL dp_1: got %02h want 79", seg_hi); n_err++;
    end
  endtask

  task automatic test_overrides();
    drive(4'h5, 1'b1, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (seg_hi !== 8'hFF) begin
      $display("FAIL blank: got %02h want FF", seg_hi); n_err++;
    end
    drive(4'h5, 1'b1, 1'b1, 1'b1);
    tick();
    n_cmp++;
    if (seg_hi !== 8'h00) begin
      $display("FAIL lamp_over_blank: got %02h want 00", seg_hi); n_err++;
    end
    drive(4'h5, 1'b1, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (seg_hi !== 8'h12) begin
      $display("FAIL override_drop: got %02h want 12", seg_hi); n_err++;
    end
  endtask

  task automatic test_polarity();
    RESET = 1'b1;
    #1;
    n_cmp++;
    if (seg_lo !== 8'h00) begin
      $display("FAIL pol_reset: got %02h want 00", seg_lo); n_err++;
    end
    tick();
    RESET = 1'b0;
    drive(4'h3, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (seg_lo !== 8'h4F) begin
      $display("FAIL pol_digit3: got %02h want 4F", seg_lo); n_err++;
    end
    drive(4'h3, 1'b0, 1'b0, 1'b1);
    tick();
    n_cmp++;
    if (seg_lo !== 8'hFF) begin
      $display("FAIL pol_lamp: got %02h want FF", seg_lo); n_err++;
    end
  endtask

  task automatic test_latency();
    drive(4'h2, 1'b0, 1'b0, 1'b0);
    tick();
    drive(4'h7, 1'b0, 1'b0, 1'b0);
    #3;
    n_cmp++;
    if (seg_hi !== 8'hA4) begin
      $display("FAIL latency_hold: got %02h want A4", seg_hi); n_err++;
    end
    tick();
    n_cmp++;
    if (seg_hi !== 8'hF8) begin
      $display("FAIL latency_update: got %02h want F8", seg_hi); n_err++;
    end
  endtask

  task automatic test_random();
    logic [3:0] d;
    logic dp, bl, lt;
    logic [7:0] exp_hi, exp_lo;
    for (int n = 0; n < 300; n++) begin
      d  = 4'($urandom_range(0, 15));
      dp = 1'($urandom_range(0, 1));
      bl = ($urandom_range(0, 3) == 0);
      lt = ($urandom_range(0, 5) == 0);
      drive(d, dp, bl, lt);
      exp_hi = model(d, dp, bl, lt, 1'b1);
      exp_lo = model(d, dp, bl, lt, 1'b0);
      tick();
      n_cmp++;
      if (seg_hi !== exp_hi) begin
        $display("FAIL rand_hi[%0d] d=%0h dp=%0b bl=%0b lt=%0b: got %02h want %02h",
                 n, d, dp, bl, lt, seg_hi, exp_hi);
        n_err++;
      end
      n_cmp++;
      if (seg_lo !== exp_lo) begin
        $display("FAIL rand_lo[%0d] d=%0h dp=%0b bl=%0b lt=%0b: got %02h want %02h",
                 n, d, dp, bl, lt, seg_lo, exp_lo);
        n_err++;
      end
    end
  endtask

  initial begin
    RESET = 1'b1;
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    RESET = 1'b0;
    tick();
    test_reset();
    test_font_sweep();
    test_dp();
    test_overrides();
    test_polarity();
    test_latency();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
